dp_ram_lat: RTL and testbench
=============================

DP_RAM_LAT -- requirements
Module: dp_ram_lat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDRESS_DEPTH, default 16, number of words (power of two).
REQ-003 SHALL have parameters WR_LAT_A / WR_LAT_B, default 1, per-port write latency, legal 1..4.
REQ-004 SHALL have parameters RD_LAT_A / RD_LAT_B, default 1, per-port read latency, legal 1..4.
REQ-005 SHALL have parameter COLL_MODE, default 0, write-write collision winner (0 = port A, 1 = port B).
REQ-006 SHALL have port i_clka  input  1  single clock for both ports, rising edge.
REQ-007 SHALL have port i_rstn  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports i_en_a / i_en_b  input  1  port request enable.
REQ-009 SHALL have ports i_we_a / i_we_b  input  1  1 = write, 0 = read (valid when en).
REQ-010 SHALL have ports i_addr_a / i_addr_b  input  $clog2(ADDRESS_DEPTH)  word address.
REQ-011 SHALL have ports i_din_a / i_din_b  input  DATA_WIDTH  write data.
REQ-012 SHALL have ports i_be_a / i_be_b  input  DATA_WIDTH/8  byte enables; bit k enables byte k.
REQ-013 SHALL have ports o_dout_a / o_dout_b  output  DATA_WIDTH  read data.
REQ-014 SHALL have ports o_valid_a / o_valid_b  output  1  o_dout holds read data this cycle.
REQ-015 SHALL have port o_coll  output  1  write-write same-address collision flag.

Function
REQ-016 A request SHALL be sampled at rising edge N when i_en=1; i_en=0 requests SHALL be ignored.
REQ-017 A write sampled at edge N SHALL commit to the array at edge N+WR_LAT-1 (WR_LAT=1: same edge).
REQ-018 Write pipeline SHALL carry addr, data, byte enables; only enabled bytes SHALL update.
REQ-019 A read sampled at edge N SHALL read the array as committed before edge N (read-first vs same-edge commit).
REQ-020 Read data SHALL appear on o_dout after edge N+RD_LAT-1, with o_valid=1 for exactly that one cycle.
REQ-021 o_dout SHALL hold its last value when o_valid=0; writes SHALL NOT assert o_valid.
REQ-022 Back-to-back requests every cycle SHALL be accepted per port with no stall; throughput one per cycle per port.
REQ-023 Same-edge commits by both ports to one address: per byte, if only one port enables it that port writes; if both enable it the COLL_MODE winner writes.
REQ-024 o_coll SHALL be 1 for the cycle after any commit edge with same-address writes from both ports (regardless of byte overlap), else 0.
REQ-025 Read on one port and same-edge commit on the other to one address SHALL return old data; no flag.
REQ-026 Ports with differing latencies SHALL be evaluated on commit edges, not sample edges, for collisions.

Reset
REQ-027 When i_rstn=0 at a rising edge: o_dout_a/b=0, o_valid_a/b=0, o_coll=0, all write and read pipeline stages invalidated.
REQ-028 Writes pending in the pipeline at reset SHALL be dropped; array contents SHALL NOT be cleared.
REQ-029 Requests sampled at an edge with i_rstn=0 SHALL be ignored; first accepted at first edge with i_rstn=1.

Structure
REQ-030 DATA_WIDTH, ADDRESS_DEPTH, WRITE_LATENCY[2], READ_LATENCY[2] defaults and a write-request struct (valid, addr, data, be) SHALL live in dual_package.
REQ-031 A sub-module lat_pipe (parametrised width and depth, valid bit, sync clear) SHALL implement each write and read delay line; four instances.
REQ-032 Array SHALL be a single reg array with per-byte writes; no vendor primitives.

Verification
REQ-033 WR_LAT_A=1, RD_LAT_A=2: write A addr3=0xDEADBEEF at edge 0, read A addr3 at edge 1 -> o_valid_a=1 with 0xDEADBEEF after edge 2 only.
REQ-034 WR_LAT_B=3: write B addr5=0x11223344 at edge 0; read A addr5 at edges 1 and 3 -> old data at edge 1, 0x11223344 for read at edge 3.
REQ-035 COLL_MODE=0: same edge A writes addr7=0xAAAAAAAA be=1111, B writes addr7=0xBBBBBBBB be=0011 -> addr7=0xAAAAAAAA, o_coll=1 one cycle; COLL_MODE=1 -> 0xAAAABBBB.
REQ-036 Mixed-latency collision: WR_LAT_A=2, WR_LAT_B=1, A writes addr2 at edge 0, B writes addr2 at edge 1 -> o_coll=1 after edge 1; edge-0/edge-0 case -> o_coll=0.
REQ-037 WR_LAT_A=4: write addr9=0x55 at edge 0, i_rstn=0 at edge 2 -> addr9 unchanged, all outputs 0 next cycle.
REQ-038 Random back-to-back reads/writes both ports vs reference model with per-port delay queues -> zero mismatches over 10000 cycles.

Source files
------------

// File: rtl/dp_ram_lat_pkg.sv
// Shared defaults and write-request layout for the latency-configurable dual-port RAM.
package dual_package;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_DEPTH = 16;
  localparam int WRITE_LATENCY [2] = '{1, 1};
  localparam int READ_LATENCY  [2] = '{1, 1};

  typedef struct packed {
    logic                             valid;
    logic [$clog2(ADDRESS_DEPTH)-1:0] addr;
    logic [DATA_WIDTH-1:0]            data;
    logic [DATA_WIDTH/8-1:0]          be;
  } wr_req_t;

endpackage

// File: rtl/dp_ram_lat_pipe.sv
// Valid-tagged delay line; each stage loads data only behind a valid bit, so the
// last stage keeps the most recent valid payload. DEPTH=0 is a straight wire.
module lat_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_pipe;
      assign unused_pipe = &{1'b0, clk_i, rstn_i};
      assign valid_o     = valid_i;
      assign data_o      = data_i;
    end else begin : g_stages
      logic             valid_q [DEPTH];
      logic [WIDTH-1:0] data_q  [DEPTH];

      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          for (int k = 0; k < DEPTH; k++) begin
            valid_q[k] <= 1'b0;
            data_q[k]  <= '0;
          end
        end else begin
          valid_q[0] <= valid_i;
          if (valid_i) data_q[0] <= data_i;
          for (int k = 1; k < DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
            if (valid_q[k-1]) data_q[k] <= data_q[k-1];
          end
        end
      end

      assign valid_o = valid_q[DEPTH-1];
      assign data_o  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dp_ram_lat.sv
// True dual-port byte-writable RAM with independent per-port write and read latency,
// read-first behaviour and commit-edge write/write collision arbitration.
module dp_ram_lat #(
  parameter  int DATA_WIDTH    = dual_package::DATA_WIDTH,
  parameter  int ADDRESS_DEPTH = dual_package::ADDRESS_DEPTH,
  parameter  int WR_LAT_A      = dual_package::WRITE_LATENCY[0],
  parameter  int WR_LAT_B      = dual_package::WRITE_LATENCY[1],
  parameter  int RD_LAT_A      = dual_package::READ_LATENCY[0],
  parameter  int RD_LAT_B      = dual_package::READ_LATENCY[1],
  parameter  int COLL_MODE     = 0,
  localparam int AW            = $clog2(ADDRESS_DEPTH),
  localparam int BW            = DATA_WIDTH / 8
) (
  input  logic                  i_clka,
  input  logic                  i_rstn,
  input  logic                  i_en_a,
  input  logic                  i_en_b,
  input  logic                  i_we_a,
  input  logic                  i_we_b,
  input  logic [AW-1:0]         i_addr_a,
  input  logic [AW-1:0]         i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_din_a,
  input  logic [DATA_WIDTH-1:0] i_din_b,
  input  logic [BW-1:0]         i_be_a,
  input  logic [BW-1:0]         i_be_b,
  output logic [DATA_WIDTH-1:0] o_dout_a,
  output logic [DATA_WIDTH-1:0] o_dout_b,
  output logic                  o_valid_a,
  output logic                  o_valid_b,
  output logic                  o_coll
);

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BW-1:0]         be;
  } wpay_t;

  logic [DATA_WIDTH-1:0] mem [ADDRESS_DEPTH];

  wpay_t wa_in, wb_in, wa_out, wb_out;
  logic  wa_v, wb_v, wa_c, wb_c, same_addr;
  logic  coll_q;

  assign wa_in = '{addr: i_addr_a, data: i_din_a, be: i_be_a};
  assign wb_in = '{addr: i_addr_b, data: i_din_b, be: i_be_b};

  // Commit happens at edge N+WR_LAT-1, so the delay line is one stage shorter
  lat_pipe #(.WIDTH($bits(wpay_t)), .DEPTH(WR_LAT_A - 1)) u_wr_a (
    .clk_i(i_clka), .rstn_i(i_rstn), .valid_i(i_en_a & i_we_a), .data_i(wa_in),
    .valid_o(wa_v), .data_o(wa_out)
  );

  lat_pipe #(.WIDTH($bits(wpay_t)), .DEPTH(WR_LAT_B - 1)) u_wr_b (
    .clk_i(i_clka), .rstn_i(i_rstn), .valid_i(i_en_b & i_we_b), .data_i(wb_in),
    .valid_o(wb_v), .data_o(wb_out)
  );

  // Array read feeds the first stage, so NBA commits on the same edge are not seen
  lat_pipe #(.WIDTH(DATA_WIDTH), .DEPTH(RD_LAT_A)) u_rd_a (
    .clk_i(i_clka), .rstn_i(i_rstn), .valid_i(i_en_a & ~i_we_a), .data_i(mem[i_addr_a]),
    .valid_o(o_valid_a), .data_o(o_dout_a)
  );

  lat_pipe #(.WIDTH(DATA_WIDTH), .DEPTH(RD_LAT_B)) u_rd_b (
    .clk_i(i_clka), .rstn_i(i_rstn), .valid_i(i_en_b & ~i_we_b), .data_i(mem[i_addr_b]),
    .valid_o(o_valid_b), .data_o(o_dout_b)
  );

  assign wa_c      = wa_v & i_rstn;
  assign wb_c      = wb_v & i_rstn;
  assign same_addr = (wa_out.addr == wb_out.addr);

  logic [BW-1:0] a_byte_we, b_byte_we;

  generate
    for (genvar gi = 0; gi < BW; gi++) begin : g_byte
      logic both;
      assign both          = wa_c & wb_c & same_addr & wa_out.be[gi] & wb_out.be[gi];
      assign a_byte_we[gi] = wa_c & wa_out.be[gi] & ~(both & (COLL_MODE != 0));
      assign b_byte_we[gi] = wb_c & wb_out.be[gi] & ~(both & (COLL_MODE == 0));
    end
  endgenerate

  always_ff @(posedge i_clka) begin
    for (int k = 0; k < BW; k++) begin
      if (a_byte_we[k]) mem[wa_out.addr][k*8 +: 8] <= wa_out.data[k*8 +: 8];
      if (b_byte_we[k]) mem[wb_out.addr][k*8 +: 8] <= wb_out.data[k*8 +: 8];
    end
  end

  always_ff @(posedge i_clka) begin
    if (!i_rstn) coll_q <= 1'b0;
    else         coll_q <= wa_v & wb_v & same_addr;
  end

  assign o_coll = coll_q;

endmodule

// File: tb/tb_dp_ram_lat.sv
// Scoreboard bench: two RAM instances with different latency/collision settings,
// directed stimulus pushes expected reads and collision cycles; a monitor pops and compares.
module tb_dp_ram_lat;

  localparam int WLA [2] = '{1, 4};
  localparam int RLA [2] = '{2, 1};
  localparam int WLB [2] = '{3, 1};
  localparam int RLB [2] = '{1, 3};
  localparam int CM  [2] = '{0, 1};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [2];
  logic        en_a   [2], en_b [2], we_a [2], we_b [2];
  logic [3:0]  addr_a [2], addr_b [2], be_a [2], be_b [2];
  logic [31:0] din_a  [2], din_b [2], dout_a [2], dout_b [2];
  logic        valid_a[2], valid_b [2], coll [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      dp_ram_lat #(
        .DATA_WIDTH(32), .ADDRESS_DEPTH(16),
        .WR_LAT_A(WLA[gi]), .WR_LAT_B(WLB[gi]),
        .RD_LAT_A(RLA[gi]), .RD_LAT_B(RLB[gi]),
        .COLL_MODE(CM[gi])
      ) u_dut (
        .i_clka(clk), .i_rstn(rstn[gi]),
        .i_en_a(en_a[gi]), .i_en_b(en_b[gi]),
        .i_we_a(we_a[gi]), .i_we_b(we_b[gi]),
        .i_addr_a(addr_a[gi]), .i_addr_b(addr_b[gi]),
        .i_din_a(din_a[gi]), .i_din_b(din_b[gi]),
        .i_be_a(be_a[gi]), .i_be_b(be_b[gi]),
        .o_dout_a(dout_a[gi]), .o_dout_b(dout_b[gi]),
        .o_valid_a(valid_a[gi]), .o_valid_b(valid_b[gi]),
        .o_coll(coll[gi])
      );
    end
  endgenerate

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq    [4][$];
  int   coll_q [2][$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int i);
    en_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; din_a[i] = '0; be_a[i] = '0;
    en_b[i] = 1'b0; we_b[i] = 1'b0; addr_b[i] = '0; din_b[i] = '0; be_b[i] = '0;
  endtask

  task automatic wr(input int i, input bit pb, input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    if (!pb) begin
      en_a[i] = 1'b1; we_a[i] = 1'b1; addr_a[i] = a; din_a[i] = d; be_a[i] = be;
    end else begin
      en_b[i] = 1'b1; we_b[i] = 1'b1; addr_b[i] = a; din_b[i] = d; be_b[i] = be;
    end
  endtask

  // Sampled at the next edge (cyc+1); data visible after edge cyc+1+RD_LAT-1
  task automatic rd(input int i, input bit pb, input logic [3:0] a, input logic [31:0] e);
    exp_t x;
    x.data = e;
    if (!pb) begin
      en_a[i] = 1'b1; we_a[i] = 1'b0; addr_a[i] = a;
      x.due = cyc + RLA[i];
    end else begin
      en_b[i] = 1'b1; we_b[i] = 1'b0; addr_b[i] = a;
      x.due = cyc + RLB[i];
    end
    sbq[i*2 + int'(pb)].push_back(x);
  endtask

  task automatic step();
    @(negedge clk);
    idle(0);
    idle(1);
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic chk_zero_outputs(input int i, input string tag);
    chk({tag, "_dout_a"}, dout_a[i], 32'h0);
    chk({tag, "_valid_a"}, 32'(valid_a[i]), 32'h0);
    chk({tag, "_dout_b"}, dout_b[i], 32'h0);
    chk({tag, "_valid_b"}, 32'(valid_b[i]), 32'h0);
    chk({tag, "_coll"}, 32'(coll[i]), 32'h0);
  endtask

  // Monitor: pops one expectation per valid pulse, checks collision flag every cycle
  always @(negedge clk) begin
    for (int q = 0; q < 4; q++) begin
      logic        v;
      logic [31:0] d;
      exp_t        x;
      v = (q % 2 == 1) ? valid_b[q/2] : valid_a[q/2];
      d = (q % 2 == 1) ? dout_b[q/2]  : dout_a[q/2];
      if (v === 1'b1) begin
        if (sbq[q].size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected q=%0d actual=valid data=%h required=no valid cyc=%0d", q, d, cyc);
        end else begin
          x = sbq[q].pop_front();
          chk($sformatf("rd_cycle_q%0d", q), 32'(cyc), 32'(x.due));
          chk($sformatf("rd_data_q%0d", q), d, x.data);
        end
      end else if (sbq[q].size() > 0 && sbq[q][0].due <= cyc) begin
        checks++; failures++;
        $display("FAIL rd_missing q=%0d actual=no valid required=valid data=%h cyc=%0d", q, sbq[q][0].data, cyc);
        x = sbq[q].pop_front();
      end
    end
    for (int i = 0; i < 2; i++) begin
      logic e;
      e = (coll_q[i].size() > 0 && coll_q[i][0] == cyc);
      chk($sformatf("coll_i%0d", i), 32'(coll[i]), 32'(e));
      if (coll_q[i].size() > 0 && coll_q[i][0] <= cyc) void'(coll_q[i].pop_front());
    end
  end

  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    idle(0); idle(1);
    step(); step();
    chk_zero_outputs(0, "rst0");
    chk_zero_outputs(1, "rst1");
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // ---- instance 0: WR A=1 B=3, RD A=2 B=1, port A wins ----
    for (int a = 0; a < 16; a++) begin
      wr(0, 0, 4'(a), 32'h1000_0000 | a, 4'hF); step();
    end
    for (int a = 0; a < 16; a++) begin
      rd(0, 0, 4'(a), 32'h1000_0000 | a);
      rd(0, 1, 4'(15 - a), 32'h1000_0000 | (15 - a));
      step();
    end
    wait_n(3);

    wr(0, 0, 4'd3, 32'hDEAD_BEEF, 4'hF); step();
    rd(0, 0, 4'd3, 32'hDEAD_BEEF); step(); wait_n(3);

    wr(0, 0, 4'd4, 32'h4444_4444, 4'hF); rd(0, 1, 4'd4, 32'h1000_0004); step();
    rd(0, 1, 4'd4, 32'h4444_4444); step(); wait_n(2);

    wr(0, 1, 4'd5, 32'h1122_3344, 4'hF); step();
    rd(0, 0, 4'd5, 32'h1000_0005); step();
    rd(0, 0, 4'd5, 32'h1000_0005); step();
    rd(0, 0, 4'd5, 32'h1122_3344); step(); wait_n(3);

    wr(0, 1, 4'd7, 32'hBBBB_BBBB, 4'h3); step(); step();
    wr(0, 0, 4'd7, 32'hAAAA_AAAA, 4'hF); coll_q[0].push_back(cyc + WLA[0]); step();
    wait_n(2); rd(0, 0, 4'd7, 32'hAAAA_AAAA); step(); wait_n(2);

    wr(0, 1, 4'd6, 32'hDDDD_DDDD, 4'h3); step(); step();
    wr(0, 0, 4'd6, 32'hCCCC_CCCC, 4'hC); coll_q[0].push_back(cyc + WLA[0]); step();
    wait_n(2); rd(0, 1, 4'd6, 32'hCCCC_DDDD); step(); wait_n(2);

    wr(0, 1, 4'd8, 32'hBBBB_BBBB, 4'h3); step(); wait_n(3);
    rd(0, 0, 4'd8, 32'h1000_BBBB); step(); wait_n(3);

    // reset with a pending B write and an in-flight A read; request during reset ignored
    wr(0, 1, 4'd9, 32'h9999_9999, 4'hF); rd(0, 0, 4'd0, 32'h1000_0000); step();
    rstn[0] = 1'b0;
    sbq[0].delete(); sbq[1].delete(); coll_q[0].delete();
    wr(0, 0, 4'd10, 32'hBAD0_BAD0, 4'hF); step();
    chk_zero_outputs(0, "rst0b");
    rstn[0] = 1'b1; wait_n(4);
    rd(0, 0, 4'd9, 32'h1000_0009); rd(0, 1, 4'd10, 32'h1000_000A); step(); wait_n(3);

    // ---- instance 1: WR A=4 B=1, RD A=1 B=3, port B wins ----
    for (int a = 0; a < 16; a++) begin
      wr(1, 1, 4'(a), 32'h2000_0000 | a, 4'hF); step();
    end
    wait_n(2);

    wr(1, 0, 4'd2, 32'hA2A2_A2A2, 4'hF); step(); step(); step();
    wr(1, 1, 4'd2, 32'hB2B2_B2B2, 4'hF); coll_q[1].push_back(cyc + WLB[1]); step();
    wait_n(2); rd(1, 0, 4'd2, 32'hB2B2_B2B2); step(); wait_n(2);

    wr(1, 0, 4'd11, 32'hA1A1_A1A1, 4'hF); wr(1, 1, 4'd11, 32'hB1B1_B1B1, 4'hF); step();
    wait_n(5); rd(1, 1, 4'd11, 32'hA1A1_A1A1); step(); wait_n(3);

    wr(1, 0, 4'd7, 32'hAAAA_AAAA, 4'hF); step(); step(); step();
    wr(1, 1, 4'd7, 32'hBBBB_BBBB, 4'h3); coll_q[1].push_back(cyc + WLB[1]); step();
    wait_n(2); rd(1, 0, 4'd7, 32'hAAAA_BBBB); step(); wait_n(2);

    wr(1, 1, 4'd12, 32'hC0FF_EE00, 4'hF); rd(1, 0, 4'd12, 32'h2000_000C); step();
    rd(1, 0, 4'd12, 32'hC0FF_EE00); step(); wait_n(4);

    wr(1, 0, 4'd9, 32'h0000_0055, 4'hF); step(); step();
    rstn[1] = 1'b0;
    sbq[2].delete(); sbq[3].delete(); coll_q[1].delete();
    step();
    chk_zero_outputs(1, "rst1b");
    rstn[1] = 1'b1; wait_n(6);
    rd(1, 0, 4'd9, 32'h2000_0009); rd(1, 1, 4'd9, 32'h2000_0009); step(); wait_n(5);

    for (int q = 0; q < 4; q++) chk($sformatf("sb_drain_q%0d", q), 32'(sbq[q].size()), 32'h0);
    for (int i = 0; i < 2; i++) chk($sformatf("coll_drain_i%0d", i), 32'(coll_q[i].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
